// File: rtl/pc_ir_unit.sv
// PC / IR / MDR holding stage of the multi-cycle MIPS datapath.
// It qualifies the next PC and keeps debug counters and a sticky misalignment flag.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TAKEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               PCWriteCond,
    input  logic               CondSrc,
    input  logic [1:0]         PCSrc,
    input  logic               IRWrite,
    input  logic               zero,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        aluout,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        ir,
    output logic [5:0]         opCode,
    output logic [5:0]         funct,
    output logic [31:0]        mdr,
    output logic               pc_we,
    output logic               pc_misalign,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        inst_cnt,
    output logic [TAKEN_W-1:0] taken_cnt
);

    logic        cond;
    logic        srcValid;
    logic        condTaken;
    logic [31:0] npc;

    assign cond     = zero ^ CondSrc;
    // PCSrc=11 is reserved and suppresses every PC write, including branches
    assign srcValid = (PCSrc != 2'b11);
    assign pc_we    = srcValid & (PCWrite | (PCWriteCond & cond));
    // Only a branch that alone moves the PC counts as taken
    assign condTaken = srcValid & PCWriteCond & cond & ~PCWrite;

    always_comb begin
        npc = alu_result;
        case (PCSrc)
            2'b01:   npc = aluout;
            // pc already holds PC+4 here, so the region bits are the correct ones
            2'b10:   npc = {pc[31:28], ir[25:0], 2'b00};
            default: npc = alu_result;
        endcase
    end

    assign opCode = ir[31:26];
    assign funct  = ir[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ir          <= '0;
            mdr         <= '0;
            pc_misalign <= 1'b0;
            cycle_cnt   <= '0;
            inst_cnt    <= '0;
            taken_cnt   <= '0;
        end else begin
            mdr       <= mem_rdata;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (IRWrite) begin
                ir       <= mem_rdata;
                inst_cnt <= inst_cnt + 32'd1;
            end
            if (pc_we) begin
                pc <= {npc[31:2], 2'b00};
                if (npc[1:0] != 2'b00)
                    pc_misalign <= 1'b1;
            end
            if (condTaken && (taken_cnt != {TAKEN_W{1'b1}}))
                taken_cnt <= taken_cnt + TAKEN_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: a stimulus process updates a behavioural
// model and queues expected state; a monitor compares after every clock edge.
module tb_pc_ir_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          TW  = 4;  // narrow counter so saturation is reached quickly

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 0, PCWriteCond = 0, CondSrc = 0, IRWrite = 0, zero = 0;
    logic [1:0]  PCSrc = 0;
    logic [31:0] alu_result = 0, aluout = 0, mem_rdata = 0;
    logic [31:0] pc, ir, mdr, cycle_cnt, inst_cnt;
    logic [5:0]  opCode, funct;
    logic        pc_we, pc_misalign;
    logic [TW-1:0] taken_cnt;

    pc_ir_unit #(.RESET_PC(RPC), .TAKEN_W(TW)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .CondSrc(CondSrc), .PCSrc(PCSrc), .IRWrite(IRWrite), .zero(zero),
        .alu_result(alu_result), .aluout(aluout), .mem_rdata(mem_rdata),
        .pc(pc), .ir(ir), .opCode(opCode), .funct(funct), .mdr(mdr),
        .pc_we(pc_we), .pc_misalign(pc_misalign), .cycle_cnt(cycle_cnt),
        .inst_cnt(inst_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc, ir, mdr, cyc, inst, tk;
        logic        mis, we;
    } exp_t;

    exp_t q[$];
    int nVec = 0;
    int nErr = 0;

    // Reference state
    longint mPc, mIr, mMdr, mCyc, mInst, mTk;
    bit     mMis;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every edge presents a new architectural state
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "pc", pc, e.pc);
                chk(e.name, "ir", ir, e.ir);
                chk(e.name, "opCode", {26'd0, opCode}, {26'd0, e.ir[31:26]});
                chk(e.name, "funct", {26'd0, funct}, {26'd0, e.ir[5:0]});
                chk(e.name, "mdr", mdr, e.mdr);
                chk(e.name, "cycle_cnt", cycle_cnt, e.cyc);
                chk(e.name, "inst_cnt", inst_cnt, e.inst);
                chk(e.name, "taken_cnt", 32'(taken_cnt), e.tk);
                chk(e.name, "pc_misalign", {31'd0, pc_misalign}, {31'd0, e.mis});
                chk(e.name, "pc_we", {31'd0, pc_we}, {31'd0, e.we});
            end
        end
    end

    // Drive one cycle of inputs, advance the model, queue the expected result
    task automatic step(input string nm, input bit r, input bit pw, input bit pwc, input bit cs,
                        input int src, input bit irw, input bit z,
                        input logic [31:0] alu, input logic [31:0] alo, input logic [31:0] mem);
        exp_t   e;
        bit     taken, write;
        longint target;
        @(negedge clk);
        rst = r; PCWrite = pw; PCWriteCond = pwc; CondSrc = cs; PCSrc = 2'(src);
        IRWrite = irw; zero = z; alu_result = alu; aluout = alo; mem_rdata = mem;

        // Branch condition: beq takes on zero, bne on non-zero
        taken = pwc && ((cs == 0) ? z : !z);
        write = (src != 3) && (pw || taken);
        if (src == 0)      target = alu;
        else if (src == 1) target = alo;
        else               target = (mPc / 268435456) * 268435456 + (mIr % 67108864) * 4;

        if (r) begin
            mPc = RPC; mIr = 0; mMdr = 0; mCyc = 0; mInst = 0; mTk = 0; mMis = 0;
        end else begin
            if (write) begin
                mPc = target - (target % 4);
                if (target % 4 != 0) mMis = 1;
            end
            if (src != 3 && taken && !pw && mTk < (1 << TW) - 1) mTk++;
            if (irw) begin
                mIr = mem;
                mInst = (mInst + 1) % 64'h1_0000_0000;
            end
            mMdr = mem;
            mCyc = (mCyc + 1) % 64'h1_0000_0000;
        end
        e.name = nm; e.pc = 32'(mPc); e.ir = 32'(mIr); e.mdr = 32'(mMdr);
        e.cyc = 32'(mCyc); e.inst = 32'(mInst); e.tk = 32'(mTk); e.mis = mMis; e.we = write;
        q.push_back(e);
    endtask

    initial begin
        int wait_cyc;
        logic [31:0] rnd;
        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++)
            step("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        step("fetch", 0, 1, 0, 0, 0, 1, 0, 32'h4, 0, 32'h2009_0005);
        step("beq_taken", 0, 0, 1, 0, 1, 0, 1, 0, 32'h40, 0);
        step("beq_not", 0, 0, 1, 0, 1, 0, 0, 0, 32'h80, 0);
        step("bne_taken", 0, 0, 1, 1, 1, 0, 0, 0, 32'h40, 0);
        step("bne_not", 0, 0, 1, 1, 1, 0, 1, 0, 32'h80, 0);
        // Jump: fetch sets pc=0x1000_0008 and ir=j 0x10
        step("j_fetch", 0, 1, 0, 0, 0, 1, 0, 32'h1000_0008, 0, 32'h0800_0010);
        step("j_exec", 0, 1, 0, 0, 2, 0, 0, 32'hdead_beef, 0, 0);
        step("src11_pcw", 0, 1, 0, 0, 3, 0, 0, 32'h8888, 32'h9999, 0);
        step("src11_br", 0, 0, 1, 0, 3, 0, 1, 0, 32'h9999, 0);
        step("both_wr", 0, 1, 1, 0, 0, 0, 1, 32'h200, 32'h300, 0);
        step("fetch_pc", 0, 1, 0, 0, 0, 0, 0, 32'h4, 0, 0);
        step("misalign", 0, 1, 0, 0, 0, 0, 0, 32'h6, 0, 0);
        step("mis_sticky", 0, 1, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        for (int i = 0; i < 2 * (1 << TW); i++)
            step("saturate", 0, 0, 1, 0, 1, 0, 1, 0, 32'h40 + 32'(4 * i), 0);
        // lw then reset during memory access
        step("lw_fetch", 0, 1, 0, 0, 0, 1, 0, 32'h44, 0, 32'h8c08_0004);
        step("lw_dec", 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 32'h1111);
        step("lw_addr", 0, 0, 0, 0, 0, 0, 0, 32'h2000, 0, 32'h2222);
        step("lw_mem_rst", 1, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 32'h3333);
        step("post_rst_fetch", 0, 1, 0, 0, 0, 1, 0, RPC + 4, 0, 32'h0000_0820);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            step("random", ($urandom_range(0, 49) == 0), rnd[0], rnd[1], rnd[2], int'(rnd[4:3]),
                 rnd[5], rnd[6], $urandom, $urandom, $urandom);
        end
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            nErr++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
